// File: rtl/mutation_unit.sv
// Mutation worker for the GA controller: copies the selected population, then flips at most
// one LFSR-chosen bit per individual, one individual per cycle, and holds the result.
module mutation_unit #(
  parameter int unsigned IND_BITS = 30,
  parameter int unsigned NUM_IND  = 250,
  parameter logic [7:0]  MUT_RATE = 8'd16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mut_start_i,
  input  logic [IND_BITS*NUM_IND-1:0]  sel_pop_i,
  output logic [IND_BITS*NUM_IND-1:0]  mut_pop_o,
  output logic                         mut_done_o
);

  localparam int unsigned POP_W = IND_BITS * NUM_IND;
  localparam int unsigned IDX_W = $clog2(NUM_IND);
  localparam int unsigned B_W   = $clog2(IND_BITS);
  localparam int unsigned OFF_W = $clog2(POP_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [POP_W-1:0]     work_q, work_d;
  logic [POP_W-1:0]     mut_pop_q, mut_pop_d;
  logic                 mut_done_q, mut_done_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [15:0]          lfsr_nxt_c;
  logic [B_W-1:0]       bit_sel_c;
  logic [8:0]           rate_diff_c;
  logic                 flip_c;
  logic                 last_c;
  logic [OFF_W-1:0]     off_c;
  logic [IND_BITS-1:0]  ind_c;

  // Galois LFSR step and flip decision for the individual at idx_q
  always_comb begin
    lfsr_nxt_c  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    bit_sel_c   = lfsr_q[8 +: B_W];
    // borrow out of lfsr[7:0] - MUT_RATE means lfsr[7:0] < MUT_RATE
    rate_diff_c = {1'b0, lfsr_q[7:0]} - {1'b0, MUT_RATE};
    flip_c      = rate_diff_c[8] && (32'(bit_sel_c) < IND_BITS);
    last_c      = (idx_q == IDX_W'(NUM_IND - 1));
    off_c       = OFF_W'(idx_q) * OFF_W'(IND_BITS);
    ind_c       = work_q[off_c +: IND_BITS]
                ^ (flip_c ? (IND_BITS'(1) << bit_sel_c) : '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (mut_start_i) state_d = S_RUN;
      S_RUN: begin
        if (!mut_start_i)  state_d = S_IDLE;
        else if (last_c)   state_d = S_DONE;
      end
      S_DONE: if (!mut_start_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    work_d     = work_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    mut_pop_d  = mut_pop_q;
    mut_done_d = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (mut_start_i) begin
          work_d = sel_pop_i;
          idx_d  = '0;
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_nxt_c;
        if (mut_start_i) begin
          work_d[off_c +: IND_BITS] = ind_c;
          if (last_c) begin
            mut_pop_d = work_d;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      mut_pop_q  <= '0;
      mut_done_q <= 1'b0;
      lfsr_q     <= SEED;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      mut_pop_q  <= mut_pop_d;
      mut_done_q <= mut_done_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
    end
  end

  assign mut_pop_o  = mut_pop_q;
  assign mut_done_o = mut_done_q;

endmodule

// File: tb/tb_mutation_unit.sv
// Bench for mutation_unit: a high-rate instance checked against an LFSR/flip model and a
// zero-rate instance that must pass the population through untouched.
module tb_mutation_unit;

  localparam int unsigned IB = 30;
  localparam int unsigned NI = 250;
  localparam int unsigned W  = IB * NI;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] sel_pop;
  logic [W-1:0] pop_hi, pop_zero;
  logic         done_hi, done_zero;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  lfsr_m;

  always #5 clk = ~clk;

  mutation_unit #(.IND_BITS(IB), .NUM_IND(NI), .MUT_RATE(8'hFF), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .mut_start_i(start), .sel_pop_i(sel_pop),
    .mut_pop_o(pop_hi), .mut_done_o(done_hi)
  );

  mutation_unit #(.IND_BITS(IB), .NUM_IND(NI), .MUT_RATE(8'h00), .SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst), .mut_start_i(start), .sel_pop_i(sel_pop),
    .mut_pop_o(pop_zero), .mut_done_o(done_zero)
  );

  typedef struct {
    logic [IB-1:0] pat;
    int            hold;
    bit            chk_hand;
    logic [IB-1:0] exp0;
    logic [IB-1:0] exp1;
    bit            chk_differs;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [IB-1:0] p);
    logic [W-1:0] r;
    for (int i = 0; i < int'(NI); i++) r[i*IB +: IB] = p;
    return r;
  endfunction

  function automatic int count_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < int'(NI); i++) if (a[i*IB +: IB] !== b[i*IB +: IB]) n++;
    return n;
  endfunction

  function automatic int count_multi(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic [IB-1:0] d;
    for (int i = 0; i < int'(NI); i++) begin
      d = a[i*IB +: IB] ^ b[i*IB +: IB];
      if ($countones(d) > 1) n++;
    end
    return n;
  endfunction

  // Reference: walk the individuals, flipping per the LFSR, stepping the LFSR each one
  task automatic model(input logic [W-1:0] s, input logic [7:0] rate, input logic [15:0] lin,
                       output logic [W-1:0] res, output logic [15:0] lout);
    logic [15:0] l;
    logic [4:0]  b;
    res = s;
    l   = lin;
    for (int i = 0; i < int'(NI); i++) begin
      b = l[12:8];
      if (l[7:0] < rate && b < 5'd30) res[i*IB + int'(b)] = ~res[i*IB + int'(b)];
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    lout = l;
  endtask

  // Full run starting at a negedge; checks latency, result, hold and release of done
  task automatic run_full(input logic [IB-1:0] pat, input int hold, output logic [W-1:0] got);
    logic [W-1:0] s, exp;
    logic [15:0]  ln;
    int           bad;
    s       = rep(pat);
    sel_pop = s;
    start   = 1'b1;
    for (int k = 0; k <= int'(NI); k++) begin
      @(negedge clk);
      if (k == 5) sel_pop = ~s;
      if (k == int'(NI) - 1) chk("done_early", 64'(done_hi), 64'd0);
    end
    chk("done_latency", 64'(done_hi), 64'd1);
    model(s, 8'hFF, lfsr_m, exp, ln);
    lfsr_m = ln;
    chk("pop_vs_model", 64'(count_diff(pop_hi, exp)), 64'd0);
    chk("popcount_le1", 64'(count_multi(pop_hi, s)), 64'd0);
    chk("rate0_passthru", 64'(count_diff(pop_zero, s)), 64'd0);
    got = pop_hi;
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (done_hi !== 1'b1 || pop_hi !== got) bad++;
    end
    if (hold > 0) chk("hold_done", 64'(bad), 64'd0);
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", 64'({done_hi, done_zero}), 64'd0);
    sel_pop = '0;
  endtask

  initial begin
    vec_t          tbl [4];
    logic [W-1:0]  got, prev;
    int            bad;

    tbl[0] = '{30'h0000_0000, 5, 1'b1, 30'h0000_1000, 30'h0000_0004, 1'b0};
    tbl[1] = '{30'h0000_0000, 0, 1'b0, 30'h0,         30'h0,         1'b1};
    tbl[2] = '{30'h2AAA_AAAA, 2, 1'b0, 30'h0,         30'h0,         1'b0};
    tbl[3] = '{30'h3FFF_FFFF, 1, 1'b0, 30'h0,         30'h0,         1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    sel_pop = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_done", 64'({done_hi, done_zero}), 64'd0);
    chk("reset_pop", 64'(|{pop_hi, pop_zero}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    lfsr_m = 16'hACE1;
    prev   = '0;

    for (int v = 0; v < 4; v++) begin
      run_full(tbl[v].pat, tbl[v].hold, got);
      if (tbl[v].chk_hand) begin
        chk("hand_ind0", 64'(got[0 +: IB]), 64'(tbl[v].exp0));
        chk("hand_ind1", 64'(got[IB +: IB]), 64'(tbl[v].exp1));
      end
      if (tbl[v].chk_differs) chk("rerun_differs", 64'(count_diff(got, prev) != 0), 64'd1);
      prev = got;
    end

    // Abort at RUN idx 10: nothing published, done never rises
    sel_pop = rep(30'h0000_0001);
    start   = 1'b1;
    for (int k = 0; k <= 10; k++) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_done", 64'(done_hi), 64'd0);
    chk("abort_pop_held", 64'(count_diff(pop_hi, prev)), 64'd0);
    bad = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (done_hi !== 1'b0 || pop_hi !== prev) bad++;
    end
    chk("abort_quiet", 64'(bad), 64'd0);

    // Async reset in the middle of a run at idx 100
    sel_pop = rep(30'h2AAA_AAAA);
    start   = 1'b1;
    for (int k = 0; k <= 100; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_pop", 64'(|pop_hi), 64'd0);
    chk("midrun_rst_done", 64'(done_hi), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    run_full(30'h2AAA_AAAA, 0, got);
    chk("post_rst_ind0", 64'(got[0 +: IB]), 64'h2AAA_BAAA);
    chk("post_rst_ind1", 64'(got[IB +: IB]), 64'h2AAA_AAAE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
